// File: rtl/led_rate_decoder_pkg.sv
// Shared constants, rate codes and FSM state for the LED blink-rate decoder.
// in_class() tests a measured half-period against one nominal class with symmetric tolerance.
package led_blinker_pkg;

  localparam int unsigned H100_DEF = 125000;
  localparam int unsigned H50_DEF  = 250000;
  localparam int unsigned H10_DEF  = 1250000;
  localparam int unsigned H1_DEF   = 12500000;
  localparam int unsigned CNT_W    = 24;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_100HZ = 2'b00;
  localparam rate_t RATE_50HZ  = 2'b01;
  localparam rate_t RATE_10HZ  = 2'b10;
  localparam rate_t RATE_1HZ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Inclusive window [h - tol, h + tol], tol = h >> sh.
  function automatic logic in_class(input logic [CNT_W:0] m, input int unsigned h,
                                    input int unsigned sh);
    logic [31:0] tol;
    logic [31:0] mm;
    tol = h >> sh;
    mm  = 32'(m);
    return (mm >= (h - tol)) && (mm <= (h + tol));
  endfunction

endpackage

// File: rtl/led_rate_decoder_if.sv
// Link between the LED synchronizer and the rate decoder: raw pin in, clean level and edge flag out.
// The master side (synchronizer) produces level/edge_flag; the slave side supplies the pin.
interface led_rate_decoder_if;
  logic led;
  logic level;
  logic edge_flag;

  modport master (input led, output level, output edge_flag);
  modport slave  (output led, input level, input edge_flag);
endinterface

// File: rtl/led_rate_decoder_sync.sv
// Two-flop synchronizer for the asynchronous LED pin plus a one-cycle edge detector.
// Edge flag is high in the cycle after the synchronized level changes.
module led_edge_sync (
  input  logic               i_clock,
  input  logic               i_reset_n,
  led_rate_decoder_if.master sync_if
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= sync_if.led;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_if.level     = r_sync;
  assign sync_if.edge_flag = r_sync ^ r_prev;

endmodule

// File: rtl/led_rate_decoder.sv
// Measures the LED half-period between edges, classifies it into one of four blink rates,
// and locks once two consecutive measurements agree; goes idle when the pin stops toggling.
module led_rate_decoder
  import led_blinker_pkg::*;
#(
  parameter int unsigned H100      = H100_DEF,
  parameter int unsigned H50       = H50_DEF,
  parameter int unsigned H10       = H10_DEF,
  parameter int unsigned H1        = H1_DEF,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned TIMEOUT   = 16000000
) (
  input  logic  i_clock,
  input  logic  i_reset_n,
  input  logic  i_led,
  output logic  o_valid,
  output rate_t o_rate_code,
  output logic  o_idle,
  output logic  o_level,
  output logic  o_error
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  led_rate_decoder_if w_if ();

  assign w_if.led = i_led;

  led_edge_sync u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .sync_if   (w_if.master)
  );

  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_meas;
  logic             w_hit;
  rate_t            w_cls;
  state_t           r_state;
  state_t           w_state_nxt;
  rate_t            r_cand;
  rate_t            w_cand_nxt;
  rate_t            r_code;
  logic             r_error;
  logic             w_error;

  assign w_edge = w_if.edge_flag;
  // One extra bit so a saturated counter still yields a correct measurement.
  assign w_meas = {1'b0, r_cnt} + (CNT_W + 1)'(1);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= '0;
    end else if (r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_hit = 1'b1;
    w_cls = RATE_100HZ;
    if (in_class(w_meas, H100, TOL_SHIFT)) begin
      w_cls = RATE_100HZ;
    end else if (in_class(w_meas, H50, TOL_SHIFT)) begin
      w_cls = RATE_50HZ;
    end else if (in_class(w_meas, H10, TOL_SHIFT)) begin
      w_cls = RATE_10HZ;
    end else if (in_class(w_meas, H1, TOL_SHIFT)) begin
      w_cls = RATE_1HZ;
    end else begin
      w_hit = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cand  <= RATE_100HZ;
      r_code  <= RATE_100HZ;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_error <= w_error;
      if (r_state == ST_CHECK && w_state_nxt == ST_LOCKED) begin
        r_code <= r_cand;
      end
    end
  end

  // An edge always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_error     = 1'b0;
    if (w_edge) begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (w_hit) begin
            w_state_nxt = ST_CHECK;
            w_cand_nxt  = w_cls;
          end else begin
            w_error = 1'b1;
          end
        end
        ST_CHECK: begin
          if (!w_hit) begin
            w_state_nxt = ST_ACQUIRE;
            w_error     = 1'b1;
          end else if (w_cls == r_cand) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_cand_nxt = w_cls;
          end
        end
        ST_LOCKED: begin
          if (!w_hit) begin
            w_state_nxt = ST_ACQUIRE;
            w_error     = 1'b1;
          end else if (w_cls != r_code) begin
            w_state_nxt = ST_CHECK;
            w_cand_nxt  = w_cls;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_cnt == TO_LAST) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    o_valid = (r_state == ST_LOCKED);
    o_idle  = (r_state == ST_IDLE);
  end

  assign o_rate_code = r_code;
  assign o_error     = r_error;
  assign o_level     = w_if.level;

endmodule

// File: tb/tb_led_rate_decoder.sv
// Directed plus randomized half-period stimulus checked against an edge-level rate model.
// The model: locked whenever the last two measurements since idle/error fall in the same class.
module tb_led_rate_decoder;
  import led_blinker_pkg::*;

  localparam int unsigned P_H100 = 125;
  localparam int unsigned P_H50  = 250;
  localparam int unsigned P_H10  = 1250;
  localparam int unsigned P_H1   = 12500;
  localparam int unsigned P_TO   = 16000;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  o_valid;
  logic  o_idle;
  logic  o_error;
  rate_t o_rate_code;

  led_rate_decoder_if tb_if ();

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int m_err_total = 0;
  int hk[4];
  bit m_idle;
  bit m_valid;
  bit exp_err;
  int m_prev;
  int last_n;
  logic [1:0] m_code;
  int sel, n, reps, tol;

  led_rate_decoder #(
    .H100(P_H100), .H50(P_H50), .H10(P_H10), .H1(P_H1), .TOL_SHIFT(4), .TIMEOUT(P_TO)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_led       (tb_if.led),
    .o_valid     (o_valid),
    .o_rate_code (o_rate_code),
    .o_idle      (o_idle),
    .o_level     (tb_if.level),
    .o_error     (o_error)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (o_error === 1'b1) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int m);
    int d;
    for (int k = 0; k < 4; k++) begin
      d = (m > hk[k]) ? (m - hk[k]) : (hk[k] - m);
      if (d <= hk[k] / 16) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_valid = 1'b0;
    m_prev  = -1;
    m_code  = 2'b00;
    exp_err = 1'b0;
  endtask

  task automatic model_edge(input int m);
    int c;
    exp_err = 1'b0;
    if (m_idle) begin
      m_idle  = 1'b0;
      m_prev  = -1;
      m_valid = 1'b0;
    end else begin
      c = classify(m);
      if (c < 0) begin
        exp_err = 1'b1;
        m_err_total++;
        m_prev  = -1;
        m_valid = 1'b0;
      end else if (c == m_prev) begin
        m_valid = 1'b1;
        m_code  = 2'(c);
      end else begin
        m_prev  = c;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, o_valid, m_valid);
    chk({tag, "_code"}, o_rate_code, m_code);
    chk({tag, "_idle"}, o_idle, m_idle);
    chk({tag, "_error"}, o_error, exp_err);
    chk({tag, "_level"}, tb_if.level, tb_if.led);
  endtask

  // Toggle the pin at a negedge, check once the edge has propagated, then hold for n clocks total.
  task automatic step(input int hp);
    tb_if.led = ~tb_if.led;
    model_edge(last_n);
    last_n = hp;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("edge");
    repeat (hp - 3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    hk[0] = P_H100; hk[1] = P_H50; hk[2] = P_H10; hk[3] = P_H1;
    tb_if.led = 1'b0;
    rst_n = 1'b0;
    last_n = 0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 100 Hz lock, no errors expected
    repeat (3) step(P_H100);
    chk("lock100_valid", o_valid, 1);
    chk("lock100_code", o_rate_code, 2'b00);
    repeat (2) step(P_H100);
    chk("lock100_noerr", err_pulses, 0);

    // 10 Hz lock, then switch to 50 Hz
    repeat (3) step(P_H10);
    chk("lock10_valid", o_valid, 1);
    chk("lock10_code", o_rate_code, 2'b10);
    step(P_H50);
    step(P_H50);
    chk("switch_drop_valid", o_valid, 0);
    chk("switch_hold_code", o_rate_code, 2'b10);
    step(P_H50);
    chk("lock50_valid", o_valid, 1);
    chk("lock50_code", o_rate_code, 2'b01);

    // Tolerance edges of the 100 Hz class: 118/132 in, 117/133 out
    step(125); step(132); step(118); step(133); step(125); step(117); step(125);

    // 1 Hz class boundaries: 11719 and 13281 lock, 13282 errors
    step(11719);
    step(13281);
    step(13282);
    chk("lock1_valid", o_valid, 1);
    chk("lock1_code", o_rate_code, 2'b11);
    step(P_H100);
    chk("lock1_out_valid", o_valid, 0);
    chk("lock1_out_code", o_rate_code, 2'b11);

    // Randomized runs over the short classes and unmatched half-periods
    for (int g = 0; g < 12; g++) begin
      sel = $urandom_range(0, 3);
      if (sel < 3) begin
        tol = hk[sel] / 16;
        n = hk[sel] - tol + $urandom_range(0, 2 * tol);
      end else begin
        n = $urandom_range(8, 1300);
      end
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) step(n);
    end

    // Reset for one cycle while locked, with the pin low
    repeat (3) step(P_H100);
    if (tb_if.led) step(P_H100);
    chk("pre_reset_valid", o_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    last_n = 0;
    check_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    step(P_H100);
    step(P_H100);
    chk("relock_pending", o_valid, 0);
    step(P_H100);
    chk("relock_valid", o_valid, 1);
    chk("relock_code", o_rate_code, 2'b00);

    // Final rising edge, then the pin stays high until the timeout
    if (tb_if.led) step(P_H100);
    tb_if.led = 1'b1;
    model_edge(last_n);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("last_edge");
    repeat (P_TO - 1) @(posedge clk);
    #1;
    chk("timeout_minus1_idle", o_idle, 0);
    chk("timeout_minus1_valid", o_valid, 1);
    @(posedge clk);
    #1;
    chk("timeout_idle", o_idle, 1);
    chk("timeout_valid", o_valid, 0);
    chk("timeout_level", tb_if.level, 1);
    chk("timeout_code", o_rate_code, 2'b00);

    chk("err_pulse_count", err_pulses, m_err_total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_rate_decoder.md
LED_RATE_DECODER -- requirements
Module: led_rate_decoder

Interface
REQ-001 The block SHALL take parameter H100, default 125000, meaning the nominal half-period in clocks for 100 Hz.
REQ-002 The block SHALL take parameter H50, default 250000, meaning the nominal half-period for 50 Hz.
REQ-003 The block SHALL take parameter H10, default 1250000, meaning the nominal half-period for 10 Hz.
REQ-004 The block SHALL take parameter H1, default 12500000, meaning the nominal half-period for 1 Hz.
REQ-005 The block SHALL take parameter TOL_SHIFT, default 4, meaning the tolerance is H>>TOL_SHIFT, which is 6.25 %.
REQ-006 The block SHALL take parameter TIMEOUT, default 16000000, meaning the number of clocks without an edge that declares the signal steady.
REQ-007 The block SHALL have port i_clock, input, 1 bit: the 25 MHz clock; this is the only clock.
REQ-008 The block SHALL have port i_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-009 The block SHALL have port i_led, input, 1 bit: the asynchronous blink waveform under test.
REQ-010 The block SHALL have port o_valid, output, 1 bit: high while a rate is locked.
REQ-011 The block SHALL have port o_rate_code, output, 2 bits: 00 = 100 Hz, 01 = 50 Hz, 10 = 10 Hz, 11 = 1 Hz; bit1 is switch_1 and bit0 is switch_2.
REQ-012 The block SHALL have port o_idle, output, 1 bit: high when no edge has been seen for TIMEOUT clocks (source disabled).
REQ-013 The block SHALL have port o_level, output, 1 bit: the synchronized i_led level.
REQ-014 The block SHALL have port o_error, output, 1 bit: a one-cycle pulse when a measured half-period matches no class.

Function
REQ-015 i_led SHALL pass through a 2-flop synchronizer; an edge is flagged when the synchronized value differs from its previous value, giving 3 clocks of latency from a pin edge to the edge flag.
REQ-016 A 24-bit counter cnt SHALL increment every clock and saturate at all ones.
- On the edge cycle: M = cnt+1, and cnt is cleared to 0.
- Edges exactly N clocks apart therefore give M = N.
REQ-017 Classification SHALL give class k when |M - Hk| <= Hk>>TOL_SHIFT; boundary values are inclusive, and Hk±tol±1 gives no match.
- With the defaults the classes do not overlap.
REQ-018 The state machine SHALL have four states: IDLE, ACQUIRE, CHECK(cand), LOCKED(code).
REQ-019 IDLE: the first edge SHALL move the FSM to ACQUIRE with no measurement.
REQ-020 ACQUIRE: an edge whose M matches class k SHALL move to CHECK with cand = k; an edge with no match SHALL stay in ACQUIRE and pulse o_error.
REQ-021 CHECK: an edge matching cand SHALL move to LOCKED(cand); an edge matching another class j SHALL move to CHECK(j); an edge with no match SHALL move to ACQUIRE and pulse o_error.
REQ-022 LOCKED(k): an edge matching k SHALL stay; an edge matching j != k SHALL move to CHECK(j); an edge with no match SHALL move to ACQUIRE and pulse o_error.
REQ-023 In any state except IDLE, cnt reaching TIMEOUT-1 with no edge SHALL move the FSM to IDLE.
REQ-024 If an edge and the timeout fall in the same cycle, the edge SHALL take priority.
REQ-025 o_valid SHALL be high exactly in LOCKED, and SHALL be registered, asserting on the clock after the confirming edge-flag cycle.
REQ-026 o_rate_code SHALL hold the locked code while o_valid=1, and SHALL hold its last value while o_valid=0.
REQ-027 o_idle SHALL be high exactly in IDLE.

Reset
REQ-028 While i_reset_n=0 at a clock edge, the block SHALL set: state IDLE, cnt 0, synchronizer flops 0, o_valid 0, o_rate_code 00, o_idle 1, o_level 0, o_error 0.
REQ-029 Reset asserted mid-measurement SHALL discard any partial measurement, and the first edge after release SHALL be treated as an IDLE first edge.

Structure
REQ-030 A shared package led_blinker_pkg SHALL hold the default half-period constants, the 2-bit rate-code constants, and the FSM state enum.
REQ-031 The synchronizer and edge detector SHALL be one sub-module, led_edge_sync, with outputs level and edge.
REQ-032 The classifier SHALL be combinational inside led_rate_decoder.

Verification
REQ-033 The bench MAY override the parameters to H100=125, H50=250, H10=1250, H1=12500, TIMEOUT=16000; the values below use these overrides.
REQ-034 Reset, then a square wave with 125-clock half-periods -> o_valid=1 with code 00 after the third edge, and o_error never pulses.
REQ-035 Half-periods of 1250, then switched to 250 -> the code goes 10 -> o_valid drops on the first 250 edge -> o_valid rises again with code 01 on the second.
REQ-036 Tolerance boundaries at the 12500 class -> half-period 13281 locks code 11; 13282 pulses o_error and the FSM returns to ACQUIRE.
REQ-037 Locked at 100 Hz, then i_led held high -> o_valid=0 and o_idle=1 exactly 16000 clocks after the last edge flag, with o_level=1.
REQ-038 i_reset_n low for one cycle while LOCKED -> all outputs at their reset values the next cycle, and relock after 3 further edges.
